// File: rtl/fifo_umbral_pkg.sv
// Shared FIFO constants and types, reused by the D, VC and main FIFOs.
package fifo_umbral_pkg;

    localparam int FIFO_DATA_WIDTH = 6;
    localparam int FIFO_ADDR_WIDTH = 2;
    localparam int FIFO_UMB_WIDTH  = 4;

    // Status flags derived from the occupancy count.
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Width large enough to hold both a threshold and the occupancy count.
    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_umbral_if.sv
// Push/pop data bus between a FIFO producer/consumer and the FIFO itself.
interface fifo_umbral_if
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) ();

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;

    modport master (
        output push,
        output pop,
        output data_in,
        input  data_out,
        input  valid_out
    );

    modport slave (
        input  push,
        input  pop,
        input  data_in,
        output data_out,
        output valid_out
    );

endinterface

// File: rtl/ram_fifo.sv
// Dual-port FIFO storage: synchronous write port, registered read port.
module ram_fifo
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Array write; contents are left uninitialised since the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register: loads on a read and otherwise holds the last word read.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_umbral.sv
// Threshold FIFO: pointer, count and flag logic around a ram_fifo storage block.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int UMB_WIDTH  = FIFO_UMB_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_L,
    fifo_umbral_if.slave         bus,
    input  logic [UMB_WIDTH-1:0] umbral_high,
    input  logic [UMB_WIDTH-1:0] umbral_low,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_error
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int CMP_WIDTH = max_width(UMB_WIDTH, ADDR_WIDTH + 1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  push_drop;
    logic                  pop_drop;
    logic [CMP_WIDTH-1:0]  count_ext;
    logic [CMP_WIDTH-1:0]  high_ext;
    logic [CMP_WIDTH-1:0]  low_ext;
    fifo_flags_t           flags;

    // Flags come straight from the registered count so threshold changes show up immediately.
    always_comb begin
        count_ext          = CMP_WIDTH'(count);
        high_ext           = CMP_WIDTH'(umbral_high);
        low_ext            = CMP_WIDTH'(umbral_low);
        flags.empty        = (count == '0);
        flags.full         = (count == (ADDR_WIDTH + 1)'(DEPTH));
        flags.almost_full  = (count_ext >= high_ext);
        flags.almost_empty = (count_ext <= low_ext);
    end

    // Accept/drop decisions; a pop frees a slot so a full FIFO can still take a push alongside it.
    always_comb begin
        pop_ok    = bus.pop && !flags.empty;
        push_ok   = bus.push && (!flags.full || pop_ok);
        push_drop = bus.push && !push_ok;
        pop_drop  = bus.pop && !pop_ok;
    end

    // Pointers wrap naturally at the depth; count tracks the net change.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // valid_out marks the cycle after an accepted pop; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bus.valid_out <= 1'b0;
            fifo_error    <= 1'b0;
        end else begin
            bus.valid_out <= pop_ok;
            if (push_drop || pop_drop) begin
                fifo_error <= 1'b1;
            end
        end
    end

    ram_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .reset_L(reset_L),
        .wr_en  (push_ok),
        .wr_addr(wr_ptr),
        .wr_data(bus.data_in),
        .rd_en  (pop_ok),
        .rd_addr(rd_ptr),
        .rd_data(bus.data_out)
    );

    assign fifo_empty   = flags.empty;
    assign fifo_full    = flags.full;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;

endmodule

// File: tb/tb_fifo_umbral.sv
// Scoreboard bench for fifo_umbral: reference queue plus occupancy model.
module tb_fifo_umbral;
    import fifo_umbral_pkg::*;

    localparam int DW    = FIFO_DATA_WIDTH;
    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int UW    = FIFO_UMB_WIDTH;
    localparam int DEPTH = 2 ** AW;
    localparam int VW    = DW + 6;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [UW-1:0] umbral_high;
    logic [UW-1:0] umbral_low;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic          fifo_error;

    fifo_umbral_if #(.DATA_WIDTH(DW)) bus ();

    fifo_umbral dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .bus         (bus),
        .umbral_high (umbral_high),
        .umbral_low  (umbral_low),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .fifo_error  (fifo_error)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    int            exp_count;
    logic          exp_err;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] sb[$];

    function automatic logic [VW-1:0] observed();
        return {bus.valid_out, bus.data_out, fifo_empty, fifo_full,
                almost_full, almost_empty, fifo_error};
    endfunction

    function automatic logic [VW-1:0] expected();
        logic e, f, af, ae;
        e  = (exp_count == 0);
        f  = (exp_count == DEPTH);
        af = (exp_count >= int'(umbral_high));
        ae = (exp_count <= int'(umbral_low));
        return {exp_valid, exp_data, e, f, af, ae, exp_err};
    endfunction

    task automatic model_reset();
        sb.delete();
        exp_count = 0;
        exp_err   = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge state.
    task automatic drive(input logic p, input logic q, input logic [DW-1:0] d);
        bit pop_ok, push_ok;
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        @(posedge clk);
        pop_ok  = q && (exp_count != 0);
        push_ok = p && ((exp_count < DEPTH) || pop_ok);
        if (pop_ok)  exp_data = sb.pop_front();
        if (push_ok) sb.push_back(d);
        exp_valid = pop_ok;
        exp_count = exp_count + int'(push_ok) - int'(pop_ok);
        if ((p && !push_ok) || (q && !pop_ok)) exp_err = 1'b1;
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic test_reset();
        bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
        umbral_high = 4'd3; umbral_low = 4'd1;
        reset_L = 1'b0;
        model_reset();
        #2;
        checks++;
        if (observed() !== expected()) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", observed(), expected());
        end
        umbral_high = 4'd0;
        #1;
        checks++;
        if (observed() !== expected()) begin
            failures++;
            $display("FAIL reset_high0 got=%h exp=%h", observed(), expected());
        end
        umbral_high = 4'd3;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b0, DW'(i));
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL fill step=%0d got=%h exp=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_thresholds();
        logic [UW-1:0] hi_tab [4] = '{4'd4, 4'd5, 4'd15, 4'd0};
        logic [UW-1:0] lo_tab [4] = '{4'd3, 4'd4, 4'd15, 4'd0};
        for (int i = 0; i < 4; i++) begin
            umbral_high = hi_tab[i];
            umbral_low  = lo_tab[i];
            #1;
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL threshold step=%0d got=%h exp=%h", i, observed(), expected());
            end
        end
        umbral_high = 4'd3;
        umbral_low  = 4'd1;
    endtask

    task automatic test_drain(input string tag);
        int n;
        n = exp_count;
        for (int i = 0; i < n + 1; i++) begin
            drive(1'b0, (i < n), '0);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL drain_%s step=%0d got=%h exp=%h", tag, i, observed(), expected());
            end
        end
    endtask

    task automatic test_overflow();
        test_fill();
        drive(1'b1, 1'b0, 6'h3F);
        checks++;
        if (observed() !== expected() || fifo_error !== 1'b1) begin
            failures++;
            $display("FAIL overflow got=%h exp=%h", observed(), expected());
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, '0);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL overflow_hold step=%0d got=%h exp=%h", i, observed(), expected());
            end
        end
        test_drain("overflow");
    endtask

    task automatic test_underflow_push();
        reset_L = 1'b0;
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
        drive(1'b1, 1'b1, 6'h2A);
        checks++;
        if (observed() !== expected() || bus.valid_out !== 1'b0 || fifo_error !== 1'b1) begin
            failures++;
            $display("FAIL underflow_push got=%h exp=%h", observed(), expected());
        end
        drive(1'b0, 1'b1, '0);
        checks++;
        if (observed() !== expected() || bus.data_out !== 6'h2A) begin
            failures++;
            $display("FAIL underflow_readback got=%h exp=%h", observed(), expected());
        end
    endtask

    task automatic test_back_to_back();
        test_fill();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, DW'(6'h30 + i));
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL wrap step=%0d got=%h exp=%h", i, observed(), expected());
            end
        end
        test_drain("wrap");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DW'(6'h21 + i));
        drive(1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 6'h25);
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        checks++;
        if (observed() !== expected()) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", observed(), expected());
        end
        bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 6'h11;
        @(posedge clk);
        #1;
        bus.push = 1'b0; bus.pop = 1'b0;
        checks++;
        if (observed() !== expected()) begin
            failures++;
            $display("FAIL reset_ignores got=%h exp=%h", observed(), expected());
        end
        @(negedge clk);
        reset_L = 1'b1;
        drive(1'b1, 1'b0, 6'h15);
        drive(1'b0, 1'b1, '0);
        checks++;
        if (observed() !== expected() || bus.data_out !== 6'h15) begin
            failures++;
            $display("FAIL after_reset got=%h exp=%h", observed(), expected());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_thresholds();
        test_drain("basic");
        test_overflow();
        test_underflow_push();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_umbral.md
FIFO_UMBRAL -- requirements
Module: fifo_umbral

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, width of each stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, so the depth is 2**ADDR_WIDTH words (4).
REQ-003 SHALL have parameter UMB_WIDTH, default 4, width of the threshold inputs.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk and reset_L.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset_L, input, 1 bit: asynchronous active-low reset.
REQ-007 Port push, input, 1 bit: write data_in this cycle.
REQ-008 Port data_in, input, DATA_WIDTH bits: word to write.
REQ-009 Port pop, input, 1 bit: read the oldest word this cycle.
REQ-010 Port umbral_high, input, UMB_WIDTH bits: almost-full threshold, driven by the condition state machine.
REQ-011 Port umbral_low, input, UMB_WIDTH bits: almost-empty threshold, driven by the condition state machine.
REQ-012 Port data_out, output, DATA_WIDTH bits: registered read word.
REQ-013 Port valid_out, output, 1 bit: data_out holds a word popped in the previous cycle.
REQ-014 Port fifo_empty, output, 1 bit: occupancy count == 0.
REQ-015 Port fifo_full, output, 1 bit: count == depth.
REQ-016 Port almost_full, output, 1 bit: count >= umbral_high.
REQ-017 Port almost_empty, output, 1 bit: count <= umbral_low.
REQ-018 Port fifo_error, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-019 Occupancy counter SHALL be ADDR_WIDTH+1 bits, range 0..depth; read and write pointers SHALL be ADDR_WIDTH bits and wrap modulo depth.
REQ-020 A push with fifo_full=0 SHALL write mem[wr_ptr], increment wr_ptr and, absent an accepted pop, increment count.
REQ-021 A pop with fifo_empty=0 SHALL load data_out from mem[rd_ptr] at the same edge, increment rd_ptr, and set valid_out=1 for exactly the next cycle (latency 1).
REQ-022 A cycle with no accepted pop SHALL drive valid_out=0; data_out SHALL hold its last value.
REQ-023 Accepted push and accepted pop in the same cycle SHALL leave count unchanged; when full, a simultaneous push and pop SHALL both be accepted.
REQ-024 A push while full with no pop SHALL be dropped (no memory, pointer or count change) and SHALL set fifo_error at the next edge.
REQ-025 A pop while empty SHALL be ignored (valid_out=0, rd_ptr unchanged) and SHALL set fifo_error; a simultaneous push in that cycle SHALL still be accepted.
REQ-026 fifo_error SHALL stay 1 until reset_L is asserted.
REQ-027 fifo_empty, fifo_full, almost_full and almost_empty SHALL be combinational from the registered count; thresholds SHALL be compared zero-extended to max(UMB_WIDTH, ADDR_WIDTH+1) bits.
REQ-028 Threshold changes SHALL take effect on the flags in the same cycle; no data is affected.
REQ-029 umbral_high=0 SHALL force almost_full=1; umbral_low >= depth SHALL force almost_empty=1 (natural compare results, no special-casing).

Reset
REQ-030 reset_L=0 SHALL immediately, asynchronously clear count, wr_ptr, rd_ptr, data_out, valid_out and fifo_error.
REQ-031 Memory contents SHALL not need clearing.
REQ-032 During reset, outputs SHALL be: fifo_empty=1, fifo_full=0, almost_empty=1 (count 0 <= any low), and almost_full=(umbral_high==0).
REQ-033 Reset asserted mid-operation SHALL discard all stored words; push/pop SHALL be ignored while reset_L=0.

Structure
REQ-034 Default widths and depth SHALL live in the shared project include file with the other FIFO constants, so the D, VC and main FIFOs reuse them.
REQ-035 Storage SHALL be a sub-module ram_fifo: dual-port, synchronous write, registered read, DATA_WIDTH x 2**ADDR_WIDTH.
REQ-036 Pointer, count and flag logic SHALL stay in fifo_umbral.

Verification
REQ-037 Reset, then 4 pushes of 0x01..0x04 -> fifo_full=1 after the 4th edge; almost_full=1 from count 3 with umbral_high=3.
REQ-038 Then 4 pops -> data_out 0x01..0x04 in order, each with valid_out=1 one cycle after its pop; fifo_empty=1 at the end.
REQ-039 Full FIFO plus push without pop -> fifo_error=1 next cycle and staying 1; count stays 4; the dropped word never appears on data_out.
REQ-040 Empty FIFO plus pop and push of 0x2A in the same cycle -> fifo_error=1, valid_out=0, count=1; the next pop returns 0x2A.
REQ-041 Full FIFO plus simultaneous push/pop for 6 cycles (wrap) -> count stays 4 and the output order is preserved.
REQ-042 Assert reset_L mid-edge with count=3 -> all outputs at reset values without waiting for clk; after release, push/pop behave as from empty.
